// File: rtl/multicycle_controller.sv
// Control unit for the multicycle RV32I datapath: state sequencer, Moore-decoded
// datapath controls with memory-ready gating, immediate selector and ALU decoder.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic       RegWrite,
  output logic       illegal_op,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_EXECI    = 4'd8;
  localparam logic [3:0] S_JAL      = 4'd9;
  localparam logic [3:0] S_BEQ      = 4'd10;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  logic [3:0] next_state_s;
  logic [1:0] alu_op_s;
  logic       pc_update_s;
  logic       branch_s;
  logic       gate_s;
  logic       op_known_s;

  // State register with synchronous reset back to FETCH.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= next_state_s;
    end
  end

  // Next-state sequencing; memory states hold until mem_ready.
  always_comb begin
    next_state_s = S_FETCH;
    case (state)
      S_FETCH:    if (mem_ready) next_state_s = S_DECODE; else next_state_s = S_FETCH;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state_s = S_MEMADR;
          OP_R:         next_state_s = S_EXECR;
          OP_I:         next_state_s = S_EXECI;
          OP_JAL:       next_state_s = S_JAL;
          OP_BEQ:       next_state_s = S_BEQ;
          default:      next_state_s = S_FETCH;
        endcase
      end
      S_MEMADR:   if (op == OP_LW) next_state_s = S_MEMREAD; else next_state_s = S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) next_state_s = S_MEMWB; else next_state_s = S_MEMREAD;
      S_MEMWB:    next_state_s = S_FETCH;
      S_MEMWRITE: if (mem_ready) next_state_s = S_FETCH; else next_state_s = S_MEMWRITE;
      S_EXECR, S_EXECI, S_JAL: next_state_s = S_ALUWB;
      S_ALUWB, S_BEQ:          next_state_s = S_FETCH;
      default:    next_state_s = S_FETCH;
    endcase
  end

  // Supported-opcode detector feeding the illegal_op pulse.
  always_comb begin
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: op_known_s = 1'b1;
      default:                                  op_known_s = 1'b0;
    endcase
  end

  // Moore decode of datapath controls from the current state.
  always_comb begin
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    alu_op_s    = 2'b00;
    RegWrite    = 1'b0;
    illegal_op  = 1'b0;
    pc_update_s = 1'b0;
    branch_s    = 1'b0;
    gate_s      = 1'b1;
    case (state)
      S_FETCH: begin
        ALUSrcB = 2'b10; ResultSrc = 2'b10;
        IRWrite = mem_ready; pc_update_s = 1'b1; gate_s = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01; ALUSrcB = 2'b01; illegal_op = ~op_known_s;
      end
      S_MEMADR:   begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; end
      S_MEMREAD:  AdrSrc = 1'b1;
      S_MEMWB:    begin ResultSrc = 2'b01; RegWrite = 1'b1; end
      S_MEMWRITE: begin AdrSrc = 1'b1; MemWrite = 1'b1; end
      S_EXECR:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b00; alu_op_s = 2'b10; end
      S_ALUWB:    RegWrite = 1'b1;
      S_EXECI:    begin ALUSrcA = 2'b10; ALUSrcB = 2'b01; alu_op_s = 2'b10; end
      S_JAL:      begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; pc_update_s = 1'b1; end
      S_BEQ:      begin ALUSrcA = 2'b10; alu_op_s = 2'b01; branch_s = 1'b1; end
      default: begin
        // Stray codes look like a FETCH that never sees mem_ready.
        ALUSrcB = 2'b10; ResultSrc = 2'b10; pc_update_s = 1'b1; gate_s = 1'b0;
      end
    endcase
  end

  assign PCWrite = (pc_update_s & gate_s) | (branch_s & zero);

  // Immediate format selector.
  always_comb begin
    case (op)
      OP_LW, OP_I: ImmSrc = 2'b00;
      OP_SW:       ImmSrc = 2'b01;
      OP_BEQ:      ImmSrc = 2'b10;
      OP_JAL:      ImmSrc = 2'b11;
      default:     ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder; only R-type (op[5]=1) may turn funct3=000 into SUB.
  always_comb begin
    case (alu_op_s)
      2'b00: ALUControl = 3'b010;
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (funct3)
          3'b000: if (op[5] & funct7b5) ALUControl = 3'b110; else ALUControl = 3'b010;
          3'b010:  ALUControl = 3'b111;
          3'b110:  ALUControl = 3'b001;
          3'b111:  ALUControl = 3'b000;
          default: ALUControl = 3'b010;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

endmodule
